de4_sopc_led_sequencer: RTL and testbench

// - Autonomous pattern scheduler for the 8-bit LED PIO slave.
// - Holds a small table of {pattern, dwell} entries loaded by the CPU over an Avalon-MM slave.
// - Steps through the table and issues Avalon-MM writes to PIO address 0.
// - Sits in DE4_SOPC between the system interconnect and the LED PIO; frees the CPU from LED timing.

---
 rtl/de4_sopc_led_pkg.sv | 20 ++
 rtl/led_seq_tick_gen.sv | 26 ++
 rtl/de4_sopc_led_sequencer.sv | 166 ++++++++++++++++
 tb/tb_de4_sopc_led_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/de4_sopc_led_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, CTRL fields, FSM encoding.
package de4_sopc_led_pkg;

    localparam logic [4:0] ADDR_CTRL       = 5'd0;
    localparam logic [4:0] ADDR_PRESCALE   = 5'd1;
    localparam logic [4:0] ADDR_STATUS     = 5'd2;
    localparam logic [4:0] ADDR_TABLE_BASE = 5'd16;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_LOOP_BIT   = 1;
    localparam int CTRL_LAST_LSB   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DWELL = 2'd3
    } seq_state_t;

endpackage

// File: rtl/led_seq_tick_gen.sv
// Prescaler down-counter; emits a one-cycle tick every period+1 cycles after clear.
module led_seq_tick_gen #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [PRESC_W-1:0] period,
    output logic               tick
);

    logic [PRESC_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || count == '0) begin
            count <= period;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = !clear && (count == '0);

endmodule

// File: rtl/de4_sopc_led_sequencer.sv
// Autonomous LED pattern scheduler: CPU-loaded {pattern, dwell} table replayed as Avalon-MM
// writes to the LED PIO.
//   state    | meaning
//   IDLE     | stopped, waiting for enable
//   LOAD     | latch TABLE[cur_idx]
//   WRITE    | PIO write strobe, held while waitrequest
//   DWELL    | hold pattern for dwell prescaler ticks
module de4_sopc_led_sequencer
    import de4_sopc_led_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int IDX_W   = 3,
    parameter int PRESC_W = 16,
    parameter int DWELL_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic        pio_waitrequest,
    output logic        busy
);

    localparam logic [4:0] DEPTH_V = 5'(DEPTH);

    seq_state_t         state, state_nxt;
    logic               enable, loop_en, enable_nxt;
    logic [IDX_W-1:0]   last_idx, cur_idx, last_wr;
    logic [PRESC_W-1:0] prescale, period;
    logic [7:0]         tbl_pattern [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell [DEPTH];
    logic [7:0]         cur_pattern;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               cfg_wr, ctrl_wr, presc_wr, tbl_hit, tbl_wr;
    logic [3:0]         last_raw;
    logic               tick, expire, at_last, done_clear;
    logic               unused_bits;

    assign cfg_wr   = cfg_chipselect && !cfg_write_n;
    assign ctrl_wr  = cfg_wr && (cfg_address == ADDR_CTRL);
    assign presc_wr = cfg_wr && (cfg_address == ADDR_PRESCALE);
    assign tbl_hit  = cfg_address[4] && ({1'b0, cfg_address[3:0]} < DEPTH_V);
    assign tbl_wr   = cfg_wr && tbl_hit;
    assign last_raw = cfg_writedata[CTRL_LAST_LSB+3:CTRL_LAST_LSB];
    assign last_wr  = ({1'b0, last_raw} >= DEPTH_V) ? IDX_W'(DEPTH-1) : last_raw[IDX_W-1:0];
    assign unused_bits = ^cfg_writedata;

    assign at_last    = (cur_idx == last_idx);
    assign expire     = (state == ST_DWELL) && tick && (dwell_cnt == DWELL_W'(1));
    assign done_clear = expire && at_last && !loop_en;
    // The FSM reacts to the enable value being written this cycle, so a start or stop
    // request is seen one cycle earlier than the register readback shows it.
    assign enable_nxt = ctrl_wr ? cfg_writedata[CTRL_ENABLE_BIT] : (enable && !done_clear);
    assign period     = presc_wr ? cfg_writedata[PRESC_W-1:0] : prescale;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable   <= 1'b0;
            loop_en  <= 1'b0;
            last_idx <= '0;
            prescale <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_pattern[i] <= '0;
                tbl_dwell[i]   <= '0;
            end
        end else begin
            enable <= enable_nxt;
            if (ctrl_wr) begin
                loop_en  <= cfg_writedata[CTRL_LOOP_BIT];
                last_idx <= last_wr;
            end
            if (presc_wr) begin
                prescale <= cfg_writedata[PRESC_W-1:0];
            end
            if (tbl_wr) begin
                tbl_pattern[cfg_address[IDX_W-1:0]] <= cfg_writedata[7:0];
                tbl_dwell[cfg_address[IDX_W-1:0]]   <= cfg_writedata[DWELL_W+7:8];
            end
        end
    end

    led_seq_tick_gen #(.PRESC_W(PRESC_W)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state != ST_DWELL) || presc_wr),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_idx     <= '0;
            cur_pattern <= '0;
            dwell_cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: cur_idx <= '0;
                ST_LOAD: begin
                    cur_pattern <= tbl_pattern[cur_idx];
                    dwell_cnt   <= (tbl_dwell[cur_idx] == '0) ? DWELL_W'(1) : tbl_dwell[cur_idx];
                end
                ST_DWELL: begin
                    if (tick && dwell_cnt != DWELL_W'(1)) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                    if (expire) begin
                        cur_idx <= at_last ? '0 : cur_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable_nxt) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = enable_nxt ? ST_WRITE : ST_IDLE;
            ST_WRITE: if (!pio_waitrequest) state_nxt = enable_nxt ? ST_DWELL : ST_IDLE;
            ST_DWELL: begin
                if (!enable_nxt) state_nxt = ST_IDLE;
                else if (expire) state_nxt = ST_LOAD;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy           = (state != ST_IDLE);
    assign pio_address    = 2'b00;
    assign pio_chipselect = (state == ST_WRITE);
    assign pio_write_n    = (state != ST_WRITE);
    assign pio_writedata  = (state == ST_WRITE) ? {24'h0, cur_pattern} : 32'h0;

    always_comb begin
        cfg_readdata = '0;
        if (tbl_hit) begin
            cfg_readdata[7:0]         = tbl_pattern[cfg_address[IDX_W-1:0]];
            cfg_readdata[DWELL_W+7:8] = tbl_dwell[cfg_address[IDX_W-1:0]];
        end else begin
            case (cfg_address)
                ADDR_CTRL: begin
                    cfg_readdata[CTRL_ENABLE_BIT]                    = enable;
                    cfg_readdata[CTRL_LOOP_BIT]                      = loop_en;
                    cfg_readdata[CTRL_LAST_LSB+IDX_W-1:CTRL_LAST_LSB] = last_idx;
                end
                ADDR_PRESCALE: cfg_readdata[PRESC_W-1:0] = prescale;
                ADDR_STATUS: begin
                    cfg_readdata[0]           = busy;
                    cfg_readdata[IDX_W+3:4]   = cur_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_de4_sopc_led_sequencer.sv
// Bench for the LED sequencer: predicts PIO write timing and data from table arithmetic.
module tb_de4_sopc_led_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  cfg_address = '0;
    logic        cfg_chipselect = 1'b0;
    logic        cfg_write_n = 1'b1;
    logic [31:0] cfg_writedata = '0;
    logic [31:0] cfg_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        pio_waitrequest = 1'b0;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] m_pat [DEPTH];
    int         m_dwell [DEPTH];
    int         m_presc = 0;
    int         m_last = 0;

    bit mon_en = 0;
    bit holding = 0;
    bit stop_on_accept = 0;
    bit wait_rand = 0;
    int fixed_hold = 0;
    int wr_count = 0;
    int n_exp = 0;
    int exp_start = 0;
    int exp_idle = 0;
    bit m_strobe;
    int m_idx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    de4_sopc_led_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_address     (cfg_address),
        .cfg_chipselect  (cfg_chipselect),
        .cfg_write_n     (cfg_write_n),
        .cfg_writedata   (cfg_writedata),
        .cfg_readdata    (cfg_readdata),
        .pio_address     (pio_address),
        .pio_chipselect  (pio_chipselect),
        .pio_write_n     (pio_write_n),
        .pio_writedata   (pio_writedata),
        .pio_waitrequest (pio_waitrequest),
        .busy            (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int dwell_cycles(input int idx);
        return ((m_dwell[idx] == 0) ? 1 : m_dwell[idx]) * (m_presc + 1);
    endfunction

    // PIO slave: stalls each write for a chosen number of cycles
    initial begin
        int hold, scnt;
        bit in_s;
        hold = 0; scnt = 0; in_s = 0;
        forever begin
            @(posedge clk); #1;
            if (pio_chipselect && !pio_write_n) begin
                if (!in_s) begin
                    hold = wait_rand ? int'($urandom_range(0, 3)) : fixed_hold;
                    scnt = 0;
                    in_s = 1;
                end
                pio_waitrequest = (scnt < hold);
                scnt++;
            end else begin
                in_s = 0;
                pio_waitrequest = 1'b0;
            end
        end
    end

    // Reference: write k carries TABLE[k mod (last+1)]; next strobe starts dwell+2 cycles after acceptance
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            m_strobe = pio_chipselect && !pio_write_n;
            m_idx = wr_count % (m_last + 1);
            if (holding) check_val("wr_held", 32'(m_strobe), 1);
            if (m_strobe && !holding) begin
                check_val("wr_extra", 32'(wr_count < n_exp), 1);
                check_val("wr_start", cyc, exp_start);
                check_val("wr_addr", 32'(pio_address), 0);
                holding = 1;
            end
            if (m_strobe) check_val("wr_data", pio_writedata, {24'h0, m_pat[m_idx]});
            else if (!holding && wr_count < n_exp && cyc == exp_start)
                check_val("wr_missing", 32'(m_strobe), 1);
            if (m_strobe && !pio_waitrequest) begin
                holding = 0;
                exp_idle = stop_on_accept ? cyc + 1 : cyc + 1 + dwell_cycles(m_idx);
                exp_start = cyc + dwell_cycles(m_idx) + 2;
                wr_count++;
            end
        end
    end

    task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
        cfg_address = a; cfg_writedata = d; cfg_chipselect = 1'b1; cfg_write_n = 1'b0;
        @(posedge clk); #1;
        cfg_chipselect = 1'b0; cfg_write_n = 1'b1;
    endtask

    task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
        cfg_address = a;
        @(negedge clk);
        d = cfg_readdata;
        @(posedge clk); #1;
    endtask

    task automatic set_presc(input int p);
        m_presc = p;
        cfg_wr(5'd1, 32'(p));
    endtask

    task automatic set_entry(input int i, input logic [7:0] p, input int dw);
        m_pat[i] = p;
        m_dwell[i] = dw;
        cfg_wr(5'(16 + i), {8'h0, 16'(dw), p});
    endtask

    task automatic start_run(input bit loop, input int last_raw, input int nexp);
        m_last = (last_raw > DEPTH - 1) ? DEPTH - 1 : last_raw;
        wr_count = 0;
        holding = 0;
        n_exp = nexp;
        exp_start = cyc + 2;
        mon_en = 1;
        cfg_wr(5'd0, (32'(last_raw) << 4) | (32'(loop) << 1) | 32'd1);
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 3000 && wr_count < n; i++) begin
            @(posedge clk); #1;
        end
        check_val("wait_wr", 32'(wr_count >= n), 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy; i++) begin
            @(posedge clk); #1;
        end
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_idle_cyc"}, cyc, exp_idle);
        check_val({tag, "_nwr"}, wr_count, n_exp);
        mon_en = 0;
    endtask

    initial begin
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            m_pat[i] = '0;
            m_dwell[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_cs", 32'(pio_chipselect), 0);
        check_val("rst_wn", 32'(pio_write_n), 1);
        check_val("rst_wd", pio_writedata, 0);
        reset = 1'b0;
        cfg_rd(5'd0, d);  check_val("rst_ctrl", d, 0);
        cfg_rd(5'd1, d);  check_val("rst_presc", d, 0);
        cfg_rd(5'd2, d);  check_val("rst_status", d, 0);

        // two-entry one-shot: 0xA5 at T+2, 0x5A at T+12
        set_presc(3);
        set_entry(0, 8'hA5, 2);
        set_entry(1, 8'h5A, 1);
        cfg_rd(5'd16, d); check_val("tbl0_rd", d, 32'h0000_02A5);
        cfg_rd(5'd30, d); check_val("unmapped_rd", d, 0);
        start_run(0, 1, 2);
        wait_idle("oneshot");
        cfg_rd(5'd0, d);  check_val("oneshot_ctrl", d, 32'h10);

        // looping with 3-cycle stalls, stopped from DWELL after five writes
        fixed_hold = 3;
        start_run(1, 1, 1000);
        wait_writes(5);
        n_exp = wr_count;
        exp_idle = cyc + 1;
        cfg_wr(5'd0, 32'h12);
        wait_idle("loopstop");
        fixed_hold = 0;

        // enable cleared while the write is stalled: exactly one write completes
        fixed_hold = 6;
        stop_on_accept = 1;
        start_run(1, 1, 1);
        for (int i = 0; i < 20 && !pio_chipselect; i++) begin
            @(posedge clk); #1;
        end
        cfg_wr(5'd0, 32'h12);
        wait_idle("wstop");
        stop_on_accept = 0;
        fixed_hold = 0;

        // dwell 0 at prescale 0, last_idx 15 clamped to 7
        set_presc(0);
        for (int i = 0; i < DEPTH; i++)
            set_entry(i, 8'($urandom), (i == 3) ? 0 : int'($urandom_range(0, 2)));
        start_run(0, 15, DEPTH);
        wait_idle("clamp");
        cfg_rd(5'd0, d);  check_val("clamp_ctrl", d, 32'h70);

        // reset while dwelling
        set_presc(3);
        set_entry(0, 8'h3C, 3);
        start_run(0, 0, 1);
        wait_writes(1);
        cfg_rd(5'd2, d);  check_val("run_status", d, 32'h01);
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_cs", 32'(pio_chipselect), 0);
        check_val("mid_rst_wn", 32'(pio_write_n), 1);
        check_val("mid_rst_wd", pio_writedata, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        check_val("post_rst_nwr", wr_count, 1);
        cfg_rd(5'd0, d);  check_val("post_rst_ctrl", d, 0);
        cfg_rd(5'd16, d); check_val("post_rst_tbl", d, 0);
        mon_en = 0;

        // randomized one-shot runs with random stalls
        wait_rand = 1;
        for (int r = 0; r < 6; r++) begin
            set_presc(int'($urandom_range(0, 3)));
            for (int i = 0; i < DEPTH; i++)
                set_entry(i, 8'($urandom), int'($urandom_range(0, 3)));
            begin
                int lr;
                lr = int'($urandom_range(0, 15));
                start_run(0, lr, ((lr > DEPTH - 1) ? DEPTH - 1 : lr) + 1);
            end
            wait_idle("rnd");
            cfg_rd(5'd0, d);  check_val("rnd_enable", d & 32'h1, 0);
        end
        wait_rand = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
